// File: rtl/axi_fifo_wr_slave.sv
// axi_fifo_wr_slave: AXI4-Lite slave front end for the write side of an
// asynchronous FIFO, entirely in the clk_axi domain.
//   0x0 DATA   (WO) full-strobe write pushes one FIFO word
//   0x4 STATUS (RO) {overflow_sticky, irq_empty, irq_full, fifo_empty, fifo_full}
//   0x8 CTRL   (WO) bit0/bit1 pulse the IRQ clears, bit2 clears overflow_sticky
//   0xC COUNT  (RW) accepted-push counter, any write clears it
// Optional build macro AXI_FIFO_WR_BACKPRESSURE_EN: a DATA push that meets a
// full FIFO waits in EXEC until space appears instead of failing with SLVERR.
module axi_fifo_wr_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  clk_axi,
  input  logic                  axi_resetn,
  input  logic [3:0]            awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [3:0]            araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_wr_full,
  input  logic                  fifo_wr_empty,
  input  logic                  irq_full,
  input  logic                  irq_empty,
  output logic                  irq_clear_full,
  output logic                  irq_clear_empty
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel state
  logic [1:0]             wr_state_q, wr_state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic [3:0]             awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;

  // Read channel state
  logic                   rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = (wr_state_q == W_RESP);
  assign bresp        = bresp_q;
  assign fifo_wr_data = wdata_q;

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Write FSM: independent AW/W capture, one-cycle EXEC action, then response
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    wr_state_d      = wr_state_q;
    awready_d       = awready_q;
    wready_d        = wready_q;
    awaddr_d        = awaddr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    bresp_d         = bresp_q;
    count_d         = count_q;
    overflow_d      = overflow_q;
    fifo_wr_en      = 1'b0;
    irq_clear_full  = 1'b0;
    irq_clear_empty = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          awaddr_d  = awaddr;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          wready_d = 1'b0;
        end
        // A dropped ready means that channel was captured in an earlier cycle.
        if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
          wr_state_d = W_EXEC;
        end
      end

      W_EXEC: begin
        wr_state_d = W_RESP;
        bresp_d    = RESP_OKAY;
        if (awaddr_q[1:0] != 2'b00) begin
          bresp_d = RESP_SLVERR;
        end else begin
          case (awaddr_q[3:2])
            REG_DATA: begin
              if (wstrb_q != 4'hF) begin
                bresp_d = RESP_SLVERR;
              end else if (fifo_wr_full) begin
`ifdef AXI_FIFO_WR_BACKPRESSURE_EN
                // Hold the transfer (and bvalid) until the FIFO has room.
                wr_state_d = W_EXEC;
`else
                bresp_d    = RESP_SLVERR;
                overflow_d = 1'b1;
`endif
              end else begin
                fifo_wr_en = 1'b1;
                count_d    = count_q + 1'b1;
              end
            end
            REG_CTRL: begin
              if (wstrb_q[0]) begin
                irq_clear_full  = wdata_q[0];
                irq_clear_empty = wdata_q[1];
                if (wdata_q[2]) begin
                  overflow_d = 1'b0;
                end
              end
            end
            REG_COUNT: begin
              count_d = '0;
            end
            default: begin
              // STATUS is read-only: the write is accepted and ignored.
            end
          endcase
        end
      end

      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end

      default: begin
        wr_state_d = W_IDLE;
        awready_d  = 1'b1;
        wready_d   = 1'b1;
      end
    endcase
  end

  // Write-side registers
  always_ff @(posedge clk_axi or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Read FSM: capture the addressed register on the AR handshake, hold until rready
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rd_state_d = R_DATA;
          rdata_d    = '0;
          rresp_d    = RESP_OKAY;
          if (araddr[1:0] != 2'b00) begin
            rresp_d = RESP_SLVERR;
          end else begin
            case (araddr[3:2])
              REG_STATUS: rdata_d[4:0] = {overflow_q, irq_empty, irq_full,
                                          fifo_wr_empty, fifo_wr_full};
              REG_COUNT:  rdata_d      = DATA_WIDTH'(count_q);
              default:    rdata_d      = '0;
            endcase
          end
        end
      end

      default: begin
        if (rready) begin
          rd_state_d = R_IDLE;
        end
      end
    endcase
  end

  // Read-side registers
  always_ff @(posedge clk_axi or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_fifo_wr_slave.sv
// Self-checking bench for axi_fifo_wr_slave: a directed vector table plus
// hand-written sequences for latency, strobe pulses, overflow, wrap and reset.
// The counter is built 8 bits wide so the wrap case needs only 2^8-1 pushes.
module tb_axi_fifo_wr_slave;

  localparam int DW = 32;
  localparam int CW = 8;

`ifdef AXI_FIFO_WR_BACKPRESSURE_EN
  localparam logic [31:0] EXP_OVF_STATUS = 32'h03;
  localparam logic [31:0] EXP_OVF_COUNT  = 32'd2;
`else
  localparam logic [31:0] EXP_OVF_STATUS = 32'h13;
  localparam logic [31:0] EXP_OVF_COUNT  = 32'd1;
`endif

  logic          clk_axi = 1'b0;
  logic          axi_resetn;
  logic [3:0]    awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [3:0]    araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_full;
  logic          fifo_wr_empty;
  logic          irq_full;
  logic          irq_empty;
  logic          irq_clear_full;
  logic          irq_clear_empty;

  always #5 clk_axi = ~clk_axi;

  axi_fifo_wr_slave #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk_axi(clk_axi), .axi_resetn(axi_resetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_wr_empty(fifo_wr_empty),
    .irq_full(irq_full), .irq_empty(irq_empty),
    .irq_clear_full(irq_clear_full), .irq_clear_empty(irq_clear_empty)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  resp;
    int          pushes;
    logic [31:0] pdata;
    int          push_cyc;  // cycles from last address/data handshake to push
    int          lat;       // cycles from last address/data handshake to bvalid
    int          clr_f;
    int          clr_e;
    bit          timeout;
  } wr_res_t;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  in_stat;   // {irq_empty, irq_full, fifo_wr_empty, fifo_wr_full}
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_push;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue a write; all times are relative to the cycle of the last handshake.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit send_aw, input bit send_w,
                           output wr_res_t r);
    bit aw_hs;
    bit w_hs;
    int hs_cyc;
    r = '{default: 0};
    r.timeout = 1'b1;
    hs_cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = send_aw; wvalid = send_w; bready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_axi);
      if (fifo_wr_en) begin
        r.pushes++;
        r.pdata    = fifo_wr_data;
        r.push_cyc = c - hs_cyc;
      end
      if (irq_clear_full)  r.clr_f++;
      if (irq_clear_empty) r.clr_e++;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (aw_hs || w_hs) hs_cyc = c;
      if (bvalid) begin
        r.resp    = bresp;
        r.lat     = c - hs_cyc;
        r.timeout = 1'b0;
      end
      @(posedge clk_axi); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (!r.timeout) break;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [1:0] resp,
                          output logic [31:0] data, output int lat, output bit timeout);
    bit ar_hs;
    int hs_cyc;
    hs_cyc = 0; lat = 0; timeout = 1'b1; resp = 2'b00; data = '0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_axi);
      if (rvalid) begin
        resp    = rresp;
        data    = rdata;
        lat     = c - hs_cyc;
        timeout = 1'b0;
      end
      ar_hs = arvalid && arready;
      if (ar_hs) hs_cyc = c;
      @(posedge clk_axi); #1;
      if (ar_hs) arvalid = 1'b0;
      if (!timeout) break;
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic set_stat(input logic [3:0] s);
    {irq_empty, irq_full, fifo_wr_empty, fifo_wr_full} = s;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_res_t     r;
    logic [1:0]  rr;
    logic [31:0] rd;
    int          rl;
    bit          rto;
    int          cnt_a;
    int          cnt_b;
    int          errs;

    axi_resetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    set_stat(4'b0000);

    vecs[0]  = '{1'b1, 4'h0, 32'hA5A5A5A5, 4'hF, 4'b0000, 2'b00, 32'h0, 1};
    vecs[1]  = '{1'b0, 4'hC, 32'h0,        4'h0, 4'b0000, 2'b00, 32'h3, 0};
    vecs[2]  = '{1'b1, 4'h0, 32'h00000011, 4'h3, 4'b0000, 2'b10, 32'h0, 0};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,        4'h0, 4'b0000, 2'b00, 32'h3, 0};
    vecs[4]  = '{1'b0, 4'h6, 32'h0,        4'h0, 4'b1111, 2'b10, 32'h0, 0};
    vecs[5]  = '{1'b1, 4'h1, 32'h00000022, 4'hF, 4'b0000, 2'b10, 32'h0, 0};
    vecs[6]  = '{1'b0, 4'h0, 32'h0,        4'h0, 4'b1111, 2'b00, 32'h0, 0};
    vecs[7]  = '{1'b0, 4'h4, 32'h0,        4'h0, 4'b0110, 2'b00, 32'h6, 0};
    vecs[8]  = '{1'b0, 4'h4, 32'h0,        4'h0, 4'b1011, 2'b00, 32'hB, 0};
    vecs[9]  = '{1'b1, 4'hC, 32'h0,        4'h0, 4'b0000, 2'b00, 32'h0, 0};
    vecs[10] = '{1'b0, 4'hC, 32'h0,        4'h0, 4'b0000, 2'b00, 32'h0, 0};
    vecs[11] = '{1'b1, 4'h0, 32'h00000001, 4'hF, 4'b0000, 2'b00, 32'h0, 1};
    vecs[12] = '{1'b0, 4'hC, 32'h0,        4'h0, 4'b0000, 2'b00, 32'h1, 0};
    vecs[13] = '{1'b0, 4'hB, 32'h0,        4'h0, 4'b0000, 2'b10, 32'h0, 0};
    vecs[14] = '{1'b0, 4'h8, 32'h0,        4'h0, 4'b0000, 2'b00, 32'h0, 0};

    // Reset values
    #12;
    check("rst_readys", {29'd0, awready, wready, arready}, 32'h7);
    check("rst_zero_ctl", {25'd0, bvalid, rvalid, fifo_wr_en, irq_clear_full,
                           irq_clear_empty, bresp}, 32'h0);
    check("rst_rresp", {30'd0, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_push_data", fifo_wr_data, 32'h0);
    @(negedge clk_axi); axi_resetn = 1'b1;
    @(posedge clk_axi); #1;

    // Same-cycle AW+W to DATA
    axi_write(4'h0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, r);
    check("a_timeout", r.timeout, 0);
    check("a_pushes", r.pushes, 1);
    check("a_push_data", r.pdata, 32'hDEADBEEF);
    check("a_push_cyc", r.push_cyc, 1);
    check("a_b_lat", r.lat, 2);
    check("a_bresp", r.resp, 2'b00);
    axi_read(4'hC, rr, rd, rl, rto);
    check("a_count", rd, 32'd1);
    check("a_count_resp", rr, 2'b00);
    check("a_r_lat", rl, 1);

    // W three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk_axi);
    check("b_wready_pre", wready, 1'b1);
    @(posedge clk_axi); #1;
    wvalid = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_axi);
      check("b_wready_low", wready, 1'b0);
      if (fifo_wr_en) cnt_a++;
      @(posedge clk_axi); #1;
    end
    axi_write(4'h0, 32'h0, 4'h0, 1'b1, 1'b0, r);
    check("b_early_push", cnt_a, 0);
    check("b_timeout", r.timeout, 0);
    check("b_pushes", r.pushes, 1);
    check("b_push_data", r.pdata, 32'h12345678);
    check("b_b_lat", r.lat, 2);
    check("b_bresp", r.resp, 2'b00);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      set_stat(vecs[i].in_stat);
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b1, 1'b1, r);
        check($sformatf("v%0d_timeout", i), r.timeout, 0);
        check($sformatf("v%0d_bresp", i), r.resp, vecs[i].exp_resp);
        check($sformatf("v%0d_pushes", i), r.pushes, vecs[i].exp_push);
        if (vecs[i].exp_push != 0)
          check($sformatf("v%0d_push_data", i), r.pdata, vecs[i].data);
      end else begin
        axi_read(vecs[i].addr, rr, rd, rl, rto);
        check($sformatf("v%0d_timeout", i), rto, 0);
        check($sformatf("v%0d_rresp", i), rr, vecs[i].exp_resp);
        check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
    end

    // DATA write against a full FIFO (count is 1 here)
    set_stat(4'b0011);
`ifdef AXI_FIFO_WR_BACKPRESSURE_EN
    fork
      axi_write(4'h0, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, r);
      begin
        repeat (6) @(posedge clk_axi);
        #2 fifo_wr_full = 1'b0;
      end
    join
    check("ovf_timeout", r.timeout, 0);
    check("ovf_bresp", r.resp, 2'b00);
    check("ovf_pushes", r.pushes, 1);
    check("ovf_push_data", r.pdata, 32'hCAFEF00D);
    check("ovf_push_cyc", r.push_cyc, 6);
    check("ovf_b_lat", r.lat, 7);
    fifo_wr_full = 1'b1;
`else
    axi_write(4'h0, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, r);
    check("ovf_timeout", r.timeout, 0);
    check("ovf_bresp", r.resp, 2'b10);
    check("ovf_pushes", r.pushes, 0);
`endif
    axi_read(4'h4, rr, rd, rl, rto);
    check("ovf_status", rd, EXP_OVF_STATUS);
    set_stat(4'b0000);
    axi_read(4'hC, rr, rd, rl, rto);
    check("ovf_count", rd, EXP_OVF_COUNT);

    // CTRL pulses and sticky clear
    axi_write(4'h8, 32'h3, 4'h1, 1'b1, 1'b1, r);
    check("ctrl_bresp", r.resp, 2'b00);
    check("ctrl_clr_full", r.clr_f, 1);
    check("ctrl_clr_empty", r.clr_e, 1);
    axi_write(4'h8, 32'h3, 4'h0, 1'b1, 1'b1, r);
    check("ctrl_nostrb_full", r.clr_f, 0);
    check("ctrl_nostrb_empty", r.clr_e, 0);
    axi_write(4'h8, 32'h4, 4'h1, 1'b1, 1'b1, r);
    check("ctrl_sticky_clr_pulses", r.clr_f + r.clr_e, 0);
    axi_read(4'h4, rr, rd, rl, rto);
    check("ctrl_status_after_clr", rd, 32'h0);

    // Counter wrap at 2^CW - 1
    axi_write(4'hC, 32'h0, 4'hF, 1'b1, 1'b1, r);
    errs = 0;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      axi_write(4'h0, i, 4'hF, 1'b1, 1'b1, r);
      if (r.timeout || r.resp != 2'b00 || r.pushes != 1) errs++;
    end
    check("wrap_preload_errs", errs, 0);
    axi_read(4'hC, rr, rd, rl, rto);
    check("wrap_all_ones", rd, (32'd1 << CW) - 32'd1);
    axi_write(4'h0, 32'h55, 4'hF, 1'b1, 1'b1, r);
    axi_read(4'hC, rr, rd, rl, rto);
    check("wrap_zero", rd, 32'h0);

    // Reset with a write response pending
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk_axi); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rto = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_axi);
      if (bvalid) begin
        rto = 1'b0;
        break;
      end
    end
    check("mr_bvalid_pending", rto, 0);
    #1 axi_resetn = 1'b0;
    #1;
    check("mr_bvalid_in_rst", bvalid, 1'b0);
    check("mr_readys_in_rst", {awready, wready, arready}, 3'b111);
    repeat (2) @(posedge clk_axi);
    @(negedge clk_axi); axi_resetn = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_axi);
      if (bvalid) cnt_a++;
      if (fifo_wr_en || rvalid) cnt_b++;
    end
    bready = 1'b0;
    check("mr_bvalid_after", cnt_a, 0);
    check("mr_push_rvalid_after", cnt_b, 0);
    @(posedge clk_axi); #1;
    axi_read(4'hC, rr, rd, rl, rto);
    check("mr_count_reset", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_fifo_wr_slave.md
Name: axi_fifo_wr_slave

Overview:
- AXI4-Lite slave front end that sits directly upstream of the asynchronous FIFO, entirely in the clk_axi domain.
- Write bursts to the DATA register become single-cycle FIFO write pushes; other registers expose status, interrupt clears and an accepted-write counter.
- It produces the awready/wready/bresp/bvalid/arready/rdata/rresp/rvalid and irq_clear_full/irq_clear_empty signals observed by the testbench interface.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata and of the FIFO write word; must be >= 32.
- COUNT_WIDTH, 16, width of the accepted-push counter.

Ports:
- clk_axi  input  1  AXI clock
- axi_resetn  input  1  asynchronous active-low reset
- awaddr  input  4  write address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  DATA_WIDTH  write data
- wstrb  input  4  write byte strobes
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bresp  output  2  write response: 00 OKAY, 10 SLVERR
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- araddr  input  4  read address
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rdata  output  DATA_WIDTH  read data
- rresp  output  2  read response
- rvalid  output  1  read data valid
- rready  input  1  read data ready
- fifo_wr_en  output  1  FIFO push strobe
- fifo_wr_data  output  DATA_WIDTH  FIFO push word
- fifo_wr_full  input  1  FIFO full, already synchronised into clk_axi
- fifo_wr_empty  input  1  FIFO empty, write-domain view
- irq_full  input  1  full interrupt level
- irq_empty  input  1  empty interrupt level
- irq_clear_full  output  1  one-cycle clear pulse
- irq_clear_empty  output  1  one-cycle clear pulse

Behaviour:
- Reset is asynchronous and active-low on axi_resetn. Every output resets to 0, except awready=1, wready=1 and arready=1. The counter, the sticky overflow bit and both FSMs reset to 0 / IDLE.
- Register map, word aligned by awaddr[3:2]:
  - 0x0 DATA: write-only; a read returns 0 with OKAY.
  - 0x4 STATUS: read-only. bit0 fifo_wr_full, bit1 fifo_wr_empty, bit2 irq_full, bit3 irq_empty, bit4 overflow_sticky; all other bits 0.
  - 0x8 CTRL: write-only. wstrb[0] gates bits[7:0]. bit0 pulses irq_clear_full, bit1 pulses irq_clear_empty, bit2 clears overflow_sticky.
  - 0xC COUNT: read returns the accepted-push count, zero-extended. Any write clears it.
- Address error: addr[1:0] != 0 on either channel gives SLVERR with no side effect; a read returns rdata=0.
- Write FSM states: IDLE, EXEC, RESP.
  - IDLE: AW and W are captured independently. awready drops after its handshake; wready drops after its handshake.
  - Both captured (including same-cycle capture) -> EXEC.
  - EXEC lasts exactly one cycle and performs the action -> RESP.
  - RESP: bvalid=1 and bresp stable until bready. Then awready=wready=1 and the FSM returns to IDLE.
  - Minimum AW+W-to-bvalid latency is 2 cycles.
- DATA push in EXEC:
  - wstrb != 4'hF: SLVERR, no push.
  - Else if fifo_wr_full=1 (sampled in EXEC): SLVERR, no push, overflow_sticky set.
  - Else: fifo_wr_en=1 for that one cycle, fifo_wr_data=wdata, counter+1, OKAY.
- Counter arithmetic is modulo 2^COUNT_WIDTH; all-ones wraps to 0.
- The CTRL clear pulses are high only in the EXEC cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On handshake, capture register contents that cycle -> R_DATA.
  - R_DATA: arready=0, rvalid=1, rdata/rresp stable until rready -> R_IDLE.
  - Read latency is 1 cycle.
- Read and write FSMs run independently. A STATUS or COUNT read captured in the same cycle as an EXEC sees the pre-EXEC values.
- Reset mid-transaction aborts it. No bvalid, rvalid or fifo_wr_en is issued after reset release for the aborted transfer.

Optional Feature:
- Macro: AXI_FIFO_WR_BACKPRESSURE_EN.
- Defined: a DATA push with full strobes and fifo_wr_full=1 stays in EXEC, with no bvalid, until fifo_wr_full=0. It then pushes with OKAY; overflow_sticky is never set by pushes.
- Undefined: SLVERR-and-drop behaviour as above.

Test Plan:
- Reset, then AW 0x0 and W 0xDEADBEEF/wstrb F in the same cycle -> fifo_wr_en pulse 1 cycle later with data 0xDEADBEEF; bvalid the next cycle with bresp 00; COUNT read returns 1.
- W issued 3 cycles before AW -> wready low after the W handshake; single push; bvalid 2 cycles after AW.
- fifo_wr_full=1, write to DATA -> no fifo_wr_en, bresp 10, STATUS read returns 0x13 when full and empty-view are both modelled as 1. With the macro defined: bvalid held off; push occurs the cycle after full drops, bresp 00.
- Write 0x3 to CTRL with wstrb 1 -> irq_clear_full and irq_clear_empty each high exactly 1 cycle; write 0x4 -> STATUS bit4 reads 0.
- Read araddr 0x6 -> rresp 10, rdata 0; write wstrb 0x3 to DATA -> bresp 10, COUNT unchanged.
- Preload COUNT to all-ones via 2^16-1 pushes, push once more -> COUNT reads 0; assert axi_resetn low with bvalid pending -> bvalid 0 immediately and after release.
